// File: rtl/ser_tx_arbiter.sv
// Round-robin arbiter sharing the SER_core transmit path between two byte requesters.
// All state advances only on the enp enable pulse; outputs come straight from registers.
module ser_tx_arbiter #(
   parameter int unsigned SETTLE_TICKS = 4,
   parameter int unsigned MAX_BURST    = 4,
   parameter int unsigned TIMEOUT      = 4000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enp,
   input  logic [1:0] req,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   input  logic [4:0] mode0,
   input  logic [4:0] mode1,
   input  logic       setSdoCompl,
   input  logic       sdoFinish,
   output logic [7:0] Dw,
   output logic       AddrDw,
   output logic [4:0] SKCTLS,
   output logic [1:0] ack,
   output logic       owner,
   output logic       busy,
   output logic       timeoutErr
);

   localparam int unsigned SW = $clog2(SETTLE_TICKS + 1);
   localparam int unsigned BW = $clog2(MAX_BURST + 1);
   localparam int unsigned TW = 16;

   typedef enum logic [2:0] {IDLE, CONFIG, SETTLE, WRITE, WAIT, DRAIN} state_e;

   state_e        state_q, nxt_c;
   logic [7:0]    dw_q;
   logic          addr_dw_q;
   logic [4:0]    skctls_q;
   logic [1:0]    ack_q;
   logic          owner_q;
   logic          busy_q;
   logic          timeout_err_q;
   logic          sent_q;
   logic [SW-1:0] settle_q;
   logic [BW-1:0] burst_q;
   logic [TW-1:0] tcnt_q;

   logic          grant_c, sel_c, sel_req_c, oth_req_c, abort_c, tmo_c;
   logic [4:0]    sel_mode_c;
   logic [7:0]    sel_data_c;
   logic [BW-1:0] burst_inc_c;

   // Requester selection: the arbitration winner while idle, otherwise the current owner.
   always_comb begin
      grant_c     = req[~owner_q] ? ~owner_q : owner_q;
      sel_c       = (state_q == IDLE) ? grant_c : owner_q;
      sel_req_c   = req[sel_c];
      oth_req_c   = req[~sel_c];
      sel_mode_c  = sel_c ? mode1 : mode0;
      sel_data_c  = sel_c ? data1 : data0;
      burst_inc_c = (burst_q == BW'(MAX_BURST)) ? burst_q : burst_q + BW'(1);
      tmo_c       = (tcnt_q == TW'(TIMEOUT - 1));
   end

   // Next-state decision; completion takes priority over timeout.
   always_comb begin
      nxt_c   = state_q;
      abort_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               if (sel_mode_c == skctls_q) nxt_c = WRITE;
               else if (sent_q)            nxt_c = DRAIN;
               else                        nxt_c = CONFIG;
            end
         end
         DRAIN: begin
            if (sdoFinish) nxt_c = CONFIG;
            else if (tmo_c) begin
               nxt_c   = IDLE;
               abort_c = 1'b1;
            end
         end
         CONFIG: nxt_c = SETTLE;
         SETTLE: begin
            if (settle_q == SW'(SETTLE_TICKS - 1)) nxt_c = sel_req_c ? WRITE : IDLE;
         end
         WRITE: nxt_c = WAIT;
         WAIT: begin
            if (setSdoCompl) begin
               if (sel_req_c && (sel_mode_c == skctls_q) &&
                   ((burst_q < BW'(MAX_BURST)) || !oth_req_c)) nxt_c = WRITE;
               else                                             nxt_c = IDLE;
            end else if (tmo_c) begin
               nxt_c   = IDLE;
               abort_c = 1'b1;
            end
         end
         default: nxt_c = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         dw_q          <= '0;
         addr_dw_q     <= 1'b0;
         skctls_q      <= '0;
         ack_q         <= '0;
         owner_q       <= 1'b1;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         sent_q        <= 1'b0;
         settle_q      <= '0;
         burst_q       <= '0;
         tcnt_q        <= '0;
      end else if (enp) begin
         state_q   <= nxt_c;
         busy_q    <= (nxt_c != IDLE);
         addr_dw_q <= 1'b0;
         ack_q     <= '0;

         // Timeout counter restarts on every state entry.
         if ((nxt_c == state_q) && ((state_q == WAIT) || (state_q == DRAIN)))
            tcnt_q <= tcnt_q + TW'(1);
         else
            tcnt_q <= '0;

         if ((state_q == IDLE) && (|req)) begin
            owner_q <= grant_c;
            burst_q <= '0;
         end
         if (state_q == CONFIG) begin
            skctls_q <= sel_mode_c;
            settle_q <= '0;
         end
         if (state_q == SETTLE) settle_q <= settle_q + SW'(1);
         if ((state_q == DRAIN) && (nxt_c == CONFIG)) sent_q <= 1'b0;
         if (abort_c) timeout_err_q <= 1'b1;

         // Entering WRITE launches the byte: strobe, data and ack for one enp period.
         if (nxt_c == WRITE) begin
            dw_q          <= sel_data_c;
            addr_dw_q     <= 1'b1;
            ack_q         <= sel_c ? 2'b10 : 2'b01;
            sent_q        <= 1'b1;
            timeout_err_q <= 1'b0;
            burst_q       <= (state_q == IDLE) ? BW'(1) : burst_inc_c;
         end
      end
   end

   assign Dw         = dw_q;
   assign AddrDw     = addr_dw_q;
   assign SKCTLS     = skctls_q;
   assign ack        = ack_q;
   assign owner      = owner_q;
   assign busy       = busy_q;
   assign timeoutErr = timeout_err_q;

endmodule
